ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter that shares the single data RAM (one synchronous write port, one combinational read port) between two requesters: port 0 is the core's load/store path, port 1 is the program/data loader or debug path. The arbiter issues at most one RAM access per cycle. It uses round-robin fairness, and a requester can lock the RAM for a bounded burst. It sits between those requesters and the RAM instance, driving the RAM's ADDR_W / ENABLE_W / Q_W / ADDR_RAM and consuming Q_RAM.

## Interface
Parameters:
- ADDR_WIDTH, 10, RAM word-address width
- DATA_WIDTH, 32, RAM data width
- MAX_BURST, 16, maximum consecutive locked cycles per burst (≥1)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  reset, synchronous, active-high
- REQ0 / REQ1  in  1  access request, held until matching GNT
- WE0 / WE1  in  1  1 = write, 0 = read
- LOCK0 / LOCK1  in  1  request/keep burst ownership
- ADDR0 / ADDR1  in  ADDR_WIDTH  word address
- WDATA0 / WDATA1  in  DATA_WIDTH  write data
- GNT0 / GNT1  out  1  combinational; access issued this cycle
- ACK0 / ACK1  out  1  registered, one-cycle pulse the cycle after GNT
- RDATA0 / RDATA1  out  DATA_WIDTH  registered read data, valid with ACK (read only)
- ADDR_W  out  ADDR_WIDTH  RAM write address
- ENABLE_W  out  1  RAM write enable
- Q_W  out  DATA_WIDTH  RAM write data
- ADDR_RAM  out  ADDR_WIDTH  RAM read address
- Q_RAM  in  DATA_WIDTH  RAM read data, combinational from ADDR_RAM

## Operation
State:
- FSM: IDLE, BURST0, BURST1
- last-grant pointer LAST (1 bit)
- burst counter CNT, width $clog2(MAX_BURST+1)

Arbitration (combinational, every cycle):
- **IDLE:**
  - Only one REQ high → that port wins.
  - Both high → port != LAST wins.
- **BURSTi, with LOCKi=1 and CNT<MAX_BURST:**
  - Port i owns the RAM.
  - If REQi=1, port i is granted.
  - If REQi=0, nobody is granted; the other port is blocked.
- **BURSTi, with LOCKi=0 or CNT==MAX_BURST:**
  - Arbitrate as in IDLE, but with LAST treated as i, so the other port wins a tie.

Access and RAM drive in the granted cycle:
- The winner's GNT=1.
- ADDR_RAM = ADDR_W = winner ADDR.
- Q_W = winner WDATA.
- ENABLE_W = winner WE.
- With no grant: ENABLE_W=0, and ADDR_W, ADDR_RAM, Q_W = 0.
- At the closing edge:
  - Write: RAM commits the write.
  - Read: Q_RAM is captured into RDATAi.
  - ACKi is set for the next cycle.
  - LAST := winner.

Burst transitions (evaluated at each edge):
- **From IDLE or on release:** a grant to i with LOCKi=1 → BURSTi, CNT:=1.
- **In BURSTi with LOCKi=1 and CNT<MAX_BURST:** CNT increments every cycle, granted or not. Idle locked cycles therefore count, which bounds starvation.
- **In BURSTi with LOCKi=0 or CNT==MAX_BURST:** the burst is released and this cycle's arbitration decides the next state:
  - winner j with LOCKj=1 → BURSTj, CNT:=1
  - otherwise → IDLE
- A granted request with LOCKi=0 in IDLE leaves the state at IDLE.

Requester rules:
- ADDR, WE, WDATA and LOCK stay stable while REQ is high and GNT is low.
- After GNT, the requester may present a new request in the very next cycle; back-to-back grants are allowed.
- RDATAi holds its value until the next read ACK on port i.
- A write ACK leaves RDATAi unchanged.

## Timing
- Grant latency: 0 cycles when uncontested and not blocked by a burst.
- ACK / RDATA latency: 1 cycle after GNT.
- Throughput: 1 access per cycle, total across both ports.
- A write to address A in cycle n is visible to a read of A in cycle n+1 from either port.
- Reset (synchronous, RESET=1 at an edge):
  - state := IDLE, CNT := 0, LAST := 1 (port 0 wins the first tie)
  - ACK0 = ACK1 = 0, RDATA0 = RDATA1 = 0
  - While RESET=1: GNT0 = GNT1 = 0, ENABLE_W = 0, RAM address/data outputs = 0
- Reset mid-operation:
  - A pending ACK is cancelled; no ACK follows the reset cycle.
  - An active burst is dropped.
  - No write is committed in any cycle where RESET=1.
- MAX_BURST=1: a locked port gets exactly one grant, and only if it wins arbitration.

## Test plan
- **Write/read round trip:** after reset, port 0 writes 0xDEADBEEF to addr 5, then reads addr 5.
  - Write cycle: GNT0=1, ENABLE_W=1, ADDR_W=5, Q_W=0xDEADBEEF.
  - Read: ACK0=1 one cycle later with RDATA0=0xDEADBEEF.
- **Contention:** REQ0 = REQ1 = 1 (reads) held for 4 cycles after reset → grants 0,1,0,1, each followed by the matching ACK.
- **Burst bound:** MAX_BURST=16; port 1 requests 20 locked reads while port 0 requests continuously → 16 consecutive GNT1, then one GNT0, then port 1 resumes.
- **Idle locked cycles:** port 1 locked with REQ1=0 for 3 cycles mid-burst → GNT0 stays 0 during those cycles, and CNT advances by 3.
- **Reset mid-operation:** RESET=1 in the cycle after a grant → no ACK, all outputs 0. Then a tie on the first post-reset cycle → GNT0.
- **Cross-port coherency:** port 1 writes 0x12345678 to addr 0x3FF in cycle n; port 0 reads 0x3FF in cycle n+1 → RDATA0=0x12345678.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one data RAM (synchronous write port, combinational
// read port) between the core load/store path (port 0) and the loader/debug
// path (port 1). One access per cycle, round-robin on ties, and a requester
// may lock the RAM for a burst bounded to MAX_BURST cycles.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic                  LOCK0,
  input  logic                  LOCK1,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  ACK0,
  output logic                  ACK1,
  output logic [DATA_WIDTH-1:0] RDATA0,
  output logic [DATA_WIDTH-1:0] RDATA1,
  output logic [ADDR_WIDTH-1:0] ADDR_W,
  output logic                  ENABLE_W,
  output logic [DATA_WIDTH-1:0] Q_W,
  output logic [ADDR_WIDTH-1:0] ADDR_RAM,
  input  logic [DATA_WIDTH-1:0] Q_RAM
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST0 = 2'd1,
    BURST1 = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ack0_q, ack1_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  logic                  held0, held1;
  logic                  tie_last;
  logic                  gnt0_c, gnt1_c;

  // Burst ownership and arbitration for the current cycle. A released burst
  // still remembers its owner so the other port wins any tie.
  always_comb begin
    held0    = (state_q == BURST0) && LOCK0 && (cnt_q < MAX_C);
    held1    = (state_q == BURST1) && LOCK1 && (cnt_q < MAX_C);
    tie_last = (state_q == BURST0) ? 1'b0 :
               (state_q == BURST1) ? 1'b1 : last_q;
    gnt0_c   = 1'b0;
    gnt1_c   = 1'b0;
    if (RESET) begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
    end else if (held0) begin
      gnt0_c = REQ0;
    end else if (held1) begin
      gnt1_c = REQ1;
    end else if (REQ0 && REQ1) begin
      gnt0_c = tie_last;
      gnt1_c = ~tie_last;
    end else begin
      gnt0_c = REQ0;
      gnt1_c = REQ1;
    end
  end

  // State register plus burst counter and last-grant pointer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state: a held burst counts every cycle (granted or idle); otherwise
  // the current winner decides whether a new burst starts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (held0 || held1) begin
      cnt_d = cnt_q + 1'b1;
    end else if (gnt0_c && LOCK0) begin
      state_d = BURST0;
      cnt_d   = CW'(1);
    end else if (gnt1_c && LOCK1) begin
      state_d = BURST1;
      cnt_d   = CW'(1);
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
    if (gnt0_c) begin
      last_d = 1'b0;
    end else if (gnt1_c) begin
      last_d = 1'b1;
    end
  end

  // Output decode: grants and the RAM drive follow the winner, all zero when idle.
  always_comb begin
    GNT0     = gnt0_c;
    GNT1     = gnt1_c;
    ENABLE_W = 1'b0;
    ADDR_W   = '0;
    ADDR_RAM = '0;
    Q_W      = '0;
    if (gnt0_c) begin
      ENABLE_W = WE0;
      ADDR_W   = ADDR0;
      ADDR_RAM = ADDR0;
      Q_W      = WDATA0;
    end else if (gnt1_c) begin
      ENABLE_W = WE1;
      ADDR_W   = ADDR1;
      ADDR_RAM = ADDR1;
      Q_W      = WDATA1;
    end
  end

  // Completion: ACK one cycle after the grant, read data captured on reads only.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= gnt0_c;
      ack1_q <= gnt1_c;
      if (gnt0_c && !WE0) begin
        rdata0_q <= Q_RAM;
      end
      if (gnt1_c && !WE1) begin
        rdata1_q <= Q_RAM;
      end
    end
  end

  // A reset arriving right after a grant cancels the ACK that is in flight.
  assign ACK0   = ack0_q & ~RESET;
  assign ACK1   = ack1_q & ~RESET;
  assign RDATA0 = rdata0_q;
  assign RDATA1 = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural RAM model on the RAM side, a table of
// per-cycle vectors for the single-access behaviour, and hand-written
// sequences for burst bounding and idle locked cycles.
module tb_ram_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ0, REQ1, WE0, WE1, LOCK0, LOCK1;
  logic [9:0]  ADDR0, ADDR1;
  logic [31:0] WDATA0, WDATA1;
  logic        GNT0, GNT1, ACK0, ACK1;
  logic [31:0] RDATA0, RDATA1;
  logic [9:0]  ADDR_W, ADDR_RAM;
  logic        ENABLE_W;
  logic [31:0] Q_W, Q_RAM;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  ram_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_BURST(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .LOCK0(LOCK0), .LOCK1(LOCK1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .ACK0(ACK0), .ACK1(ACK1),
    .RDATA0(RDATA0), .RDATA1(RDATA1),
    .ADDR_W(ADDR_W), .ENABLE_W(ENABLE_W), .Q_W(Q_W),
    .ADDR_RAM(ADDR_RAM), .Q_RAM(Q_RAM)
  );

  // RAM model: unwritten words read back as 0xA0000000 | address.
  logic [31:0] mem [0:1023];
  bit          written [0:1023];
  always @(posedge CLK) begin
    if (ENABLE_W) begin
      mem[ADDR_W]     <= Q_W;
      written[ADDR_W] <= 1'b1;
    end
  end
  assign Q_RAM = written[ADDR_RAM] ? mem[ADDR_RAM] : (32'hA000_0000 | {22'd0, ADDR_RAM});

  typedef struct {
    logic        rst, req0, req1, we0, we1, lock0, lock1;
    logic [9:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        g0, g1, en;
    logic [9:0]  aw;
    logic [31:0] qw;
    logic        k0, k1;
    logic [31:0] r0, r1;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic r0, input logic r1,
                       input logic w0, input logic w1, input logic l0, input logic l1,
                       input logic [9:0] a0, input logic [9:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    RESET = rst; REQ0 = r0; REQ1 = r1; WE0 = w0; WE1 = w1;
    LOCK0 = l0; LOCK1 = l1; ADDR0 = a0; ADDR1 = a1; WDATA0 = d0; WDATA1 = d1;
  endtask

  // One locked-burst cycle: reads of addr 1 (port 0) and 2 (port 1).
  task automatic burst_step(input string tag, input int c, input logic r0, input logic r1,
                            input logic l1, input logic e0, input logic e1);
    drive(1'b0, r0, r1, 1'b0, 1'b0, 1'b0, l1, 10'd1, 10'd2, 32'd0, 32'd0);
    @(negedge CLK);
    $display("%s cycle %0d: req0=%0b req1=%0b lock1=%0b gnt0=%0b gnt1=%0b",
             tag, c, r0, r1, l1, GNT0, GNT1);
    chk($sformatf("%s[%0d].gnt0", tag, c), {31'd0, GNT0}, {31'd0, e0});
    chk($sformatf("%s[%0d].gnt1", tag, c), {31'd0, GNT1}, {31'd0, e1});
    @(posedge CLK); #1;
  endtask

  initial begin
    //            rst r0 r1 w0 w1 l0 l1 a0     a1      d0            d1            g0 g1 en aw      qw            k0 k1 r0            r1
    vecs[0]  = '{0, 1, 0, 1, 0, 0, 0, 10'd5, 10'd0,  32'hDEADBEEF, 32'h0,        1, 0, 1, 10'd5,  32'hDEADBEEF, 0, 0, 32'h0,        32'h0};
    vecs[1]  = '{0, 1, 0, 0, 0, 0, 0, 10'd5, 10'd0,  32'h0,        32'h0,        1, 0, 0, 10'd5,  32'h0,        1, 0, 32'h0,        32'h0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 10'd0, 10'd0,  32'h0,        32'h0,        0, 0, 0, 10'd0,  32'h0,        1, 0, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 10'd0, 10'd0,  32'h0,        32'h0,        0, 0, 0, 10'd0,  32'h0,        0, 0, 32'hDEADBEEF, 32'h0};
    vecs[4]  = '{1, 0, 0, 0, 0, 0, 0, 10'd0, 10'd0,  32'h0,        32'h0,        0, 0, 0, 10'd0,  32'h0,        0, 0, 32'hDEADBEEF, 32'h0};
    vecs[5]  = '{0, 1, 1, 0, 0, 0, 0, 10'd5, 10'd7,  32'h0,        32'h0,        1, 0, 0, 10'd5,  32'h0,        0, 0, 32'h0,        32'h0};
    vecs[6]  = '{0, 1, 1, 0, 0, 0, 0, 10'd5, 10'd7,  32'h0,        32'h0,        0, 1, 0, 10'd7,  32'h0,        1, 0, 32'hDEADBEEF, 32'h0};
    vecs[7]  = '{0, 1, 1, 0, 0, 0, 0, 10'd5, 10'd7,  32'h0,        32'h0,        1, 0, 0, 10'd5,  32'h0,        0, 1, 32'hDEADBEEF, 32'hA0000007};
    vecs[8]  = '{0, 1, 1, 0, 0, 0, 0, 10'd5, 10'd7,  32'h0,        32'h0,        0, 1, 0, 10'd7,  32'h0,        1, 0, 32'hDEADBEEF, 32'hA0000007};
    vecs[9]  = '{0, 0, 1, 0, 1, 0, 0, 10'd0, 10'h3FF, 32'h0,       32'h12345678, 0, 1, 1, 10'h3FF, 32'h12345678, 0, 1, 32'hDEADBEEF, 32'hA0000007};
    vecs[10] = '{0, 1, 0, 0, 0, 0, 0, 10'h3FF, 10'd0, 32'h0,       32'h0,        1, 0, 0, 10'h3FF, 32'h0,       0, 1, 32'hDEADBEEF, 32'hA0000007};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 10'd0, 10'd0,  32'h0,        32'h0,        0, 0, 0, 10'd0,  32'h0,        1, 0, 32'h12345678, 32'hA0000007};
    vecs[12] = '{0, 1, 0, 0, 0, 0, 0, 10'd5, 10'd0,  32'h0,        32'h0,        1, 0, 0, 10'd5,  32'h0,        0, 0, 32'h12345678, 32'hA0000007};
    vecs[13] = '{1, 1, 1, 1, 1, 1, 1, 10'd9, 10'd9,  32'h55,       32'h66,       0, 0, 0, 10'd0,  32'h0,        0, 0, 32'hDEADBEEF, 32'hA0000007};
    vecs[14] = '{0, 1, 1, 0, 0, 0, 0, 10'd9, 10'h3FF, 32'h0,       32'h0,        1, 0, 0, 10'd9,  32'h0,        0, 0, 32'h0,        32'h0};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 10'd0, 10'd0,  32'h0,        32'h0,        0, 0, 0, 10'd0,  32'h0,        1, 0, 32'hA0000009, 32'h0};

    // Reset with both ports requesting writes: nothing may be granted or written.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd3, 10'd4, 32'h11, 32'h22);
    @(negedge CLK);
    chk("rst.gnt0", {31'd0, GNT0}, 32'd0);
    chk("rst.gnt1", {31'd0, GNT1}, 32'd0);
    chk("rst.enable_w", {31'd0, ENABLE_W}, 32'd0);
    chk("rst.addr_w", {22'd0, ADDR_W}, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    $display("reset: ack0=%0b ack1=%0b rdata0=%h rdata1=%h", ACK0, ACK1, RDATA0, RDATA1);
    chk("rst.ack0", {31'd0, ACK0}, 32'd0);
    chk("rst.ack1", {31'd0, ACK1}, 32'd0);
    chk("rst.rdata0", RDATA0, 32'd0);
    chk("rst.rdata1", RDATA1, 32'd0);
    @(posedge CLK); #1;

    // Table-driven single-access vectors.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].req0, vecs[i].req1, vecs[i].we0, vecs[i].we1,
            vecs[i].lock0, vecs[i].lock1, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      @(negedge CLK);
      $display("vec %0d: gnt=%0b%0b en=%0b addr_w=%h q_w=%h ack=%0b%0b rdata0=%h rdata1=%h",
               i, GNT0, GNT1, ENABLE_W, ADDR_W, Q_W, ACK0, ACK1, RDATA0, RDATA1);
      chk($sformatf("vec%0d.gnt0", i), {31'd0, GNT0}, {31'd0, vecs[i].g0});
      chk($sformatf("vec%0d.gnt1", i), {31'd0, GNT1}, {31'd0, vecs[i].g1});
      chk($sformatf("vec%0d.enable_w", i), {31'd0, ENABLE_W}, {31'd0, vecs[i].en});
      chk($sformatf("vec%0d.addr_w", i), {22'd0, ADDR_W}, {22'd0, vecs[i].aw});
      chk($sformatf("vec%0d.addr_ram", i), {22'd0, ADDR_RAM}, {22'd0, vecs[i].aw});
      chk($sformatf("vec%0d.q_w", i), Q_W, vecs[i].qw);
      chk($sformatf("vec%0d.ack0", i), {31'd0, ACK0}, {31'd0, vecs[i].k0});
      chk($sformatf("vec%0d.ack1", i), {31'd0, ACK1}, {31'd0, vecs[i].k1});
      chk($sformatf("vec%0d.rdata0", i), RDATA0, vecs[i].r0);
      chk($sformatf("vec%0d.rdata1", i), RDATA1, vecs[i].r1);
      @(posedge CLK); #1;
    end

    // Burst bound: port 1 locked against continuous port 0 traffic gets 16
    // grants, then port 0 gets one, then port 1 resumes.
    for (int c = 1; c <= 18; c++) begin
      burst_step("bound", c, 1'b1, 1'b1, 1'b1, (c == 17), (c != 17));
    end
    burst_step("bound", 19, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Idle locked cycles: port 1 drops REQ1 for 3 cycles while keeping LOCK1;
    // port 0 stays blocked and those cycles count, so release comes after 13 grants.
    for (int c = 1; c <= 17; c++) begin
      burst_step("idlelock", c, (c != 1), !(c >= 6 && c <= 8), 1'b1,
                 (c == 17), (c <= 5) || (c >= 9 && c <= 16));
    end
    burst_step("idlelock", 18, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
